pc_target_table: RTL and testbench

//  Programmable, parametrised branch-target lookup table for the fetch stage.

---
 rtl/pc_target_table.sv | 126 ++++++++++++
 tb/tb_pc_target_table.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/pc_target_table.sv
// pc_target_table: programmable branch-target lookup table for the fetch stage.
// Maps a short entry index to a full PC target. After reset the table spends
// exactly DEPTH cycles initialising every entry to its own index (unprogrammed),
// then accepts single-cycle-latency lookups and run-time writes.
// Optional feature macro: PCT_REL_EN adds the wr_rel port and per-entry
// PC-relative mode (target = pc_curr + signed offset, modulo 2**PC_W).
module pc_target_table #(
  parameter int ADDR_W = 4,
  parameter int PC_W   = 10
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic [PC_W-1:0]   pc_curr,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [PC_W-1:0]   wr_data,
`ifdef PCT_REL_EN
  input  logic              wr_rel,
`endif
  output logic              ready,
  output logic [PC_W-1:0]   target,
  output logic              target_vld,
  output logic              hit
);

  localparam int DEPTH = 2**ADDR_W;

  typedef enum logic {
    ST_INIT,
    ST_IDLE
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] init_cnt;

  logic [PC_W-1:0]   entry_data [DEPTH];
  logic [DEPTH-1:0]  entry_valid;
`ifdef PCT_REL_EN
  logic [DEPTH-1:0]  entry_rel;
`endif

  logic              bypass;
  logic [PC_W-1:0]   sel_data;
  logic              sel_valid;
  logic [PC_W-1:0]   lookup;
  logic              accept;

  assign accept = (state == ST_IDLE);

`ifdef PCT_REL_EN
  logic              sel_rel;

  // Resolve the looked-up entry, forwarding a same-index write, and apply relative mode
  always_comb begin
    bypass    = wr_en && (wr_addr == rd_addr);
    sel_data  = bypass ? wr_data : entry_data[rd_addr];
    sel_valid = bypass | entry_valid[rd_addr];
    sel_rel   = bypass ? wr_rel : entry_rel[rd_addr];
    lookup    = sel_rel ? (pc_curr + sel_data) : sel_data;
  end
`else
  logic              unused_pc;
  assign unused_pc = ^pc_curr;

  // Resolve the looked-up entry, forwarding a same-index write (absolute entries only)
  always_comb begin
    bypass    = wr_en && (wr_addr == rd_addr);
    sel_data  = bypass ? wr_data : entry_data[rd_addr];
    sel_valid = bypass | entry_valid[rd_addr];
    lookup    = sel_data;
  end
`endif

  // Entry storage: init sweep clears one entry per cycle, then run-time writes take over
  always_ff @(posedge clk) begin
    if (state == ST_INIT) begin
      entry_data[init_cnt]  <= PC_W'(init_cnt);
      entry_valid[init_cnt] <= 1'b0;
`ifdef PCT_REL_EN
      entry_rel[init_cnt]   <= 1'b0;
`endif
    end else if (wr_en) begin
      entry_data[wr_addr]   <= wr_data;
      entry_valid[wr_addr]  <= 1'b1;
`ifdef PCT_REL_EN
      entry_rel[wr_addr]    <= wr_rel;
`endif
    end
  end

  // Control FSM with registered ready and lookup results
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ST_INIT;
      init_cnt   <= '0;
      ready      <= 1'b0;
      target     <= '0;
      target_vld <= 1'b0;
      hit        <= 1'b0;
    end else begin
      target_vld <= 1'b0;
      case (state)
        ST_INIT: begin
          init_cnt <= init_cnt + ADDR_W'(1);
          if (init_cnt == ADDR_W'(DEPTH - 1)) begin
            state <= ST_IDLE;
            ready <= 1'b1;
          end
        end
        ST_IDLE: begin
          if (accept && rd_req) begin
            target     <= lookup;
            hit        <= sel_valid;
            target_vld <= 1'b1;
          end
        end
        default: begin
          state <= ST_INIT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pc_target_table.sv
// tb_pc_target_table: randomized self-checking bench for pc_target_table with
// an array-based reference model of the table contents and init timing.
module tb_pc_target_table;

  localparam int ADDR_W = 4;
  localparam int PC_W   = 10;
  localparam int DEPTH  = 16;
`ifdef PCT_REL_EN
  localparam bit RelEn = 1'b1;
`else
  localparam bit RelEn = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              reset_n;
  logic              rd_req;
  logic [ADDR_W-1:0] rd_addr;
  logic [PC_W-1:0]   pc_curr;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [PC_W-1:0]   wr_data;
`ifdef PCT_REL_EN
  logic              wr_rel;
`endif
  logic              ready;
  logic [PC_W-1:0]   target;
  logic              target_vld;
  logic              hit;

  int checks = 0;
  int errors = 0;

  int mData [DEPTH];
  bit mValid [DEPTH];
  bit mRel [DEPTH];
  int mInitLeft;
  bit mReady;
  int mTarget;
  bit mHit;
  bit mVld;

  always #5 clk = ~clk;

  pc_target_table #(.ADDR_W(ADDR_W), .PC_W(PC_W)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .rd_req     (rd_req),
    .rd_addr    (rd_addr),
    .pc_curr    (pc_curr),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
`ifdef PCT_REL_EN
    .wr_rel     (wr_rel),
`endif
    .ready      (ready),
    .target     (target),
    .target_vld (target_vld),
    .hit        (hit)
  );

  task automatic checkOutput(input string tag, input int observed, input int expected);
    checks++;
    if (observed != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic checkAll(input string tag);
    checkOutput({tag, ".ready"}, int'(ready), int'(mReady));
    checkOutput({tag, ".vld"}, int'(target_vld), int'(mVld));
    checkOutput({tag, ".target"}, int'(target), mTarget);
    checkOutput({tag, ".hit"}, int'(hit), int'(mHit));
  endtask

  task automatic modelReset();
    for (int i = 0; i < DEPTH; i++) begin
      mData[i]  = i;
      mValid[i] = 1'b0;
      mRel[i]   = 1'b0;
    end
    mInitLeft = DEPTH;
    mReady    = 1'b0;
    mTarget   = 0;
    mHit      = 1'b0;
    mVld      = 1'b0;
  endtask

  // Target rule: absolute entries return stored value; relative ones add a signed offset mod 1024
  function automatic int resolve(input int data, input bit rel, input int pc);
    int off;
    if (!rel) return data;
    off = (data >= 512) ? data - 1024 : data;
    return (((pc + off) % 1024) + 1024) % 1024;
  endfunction

  task automatic applyStimulus(input bit rd, input int ra, input int pc, input bit we,
                               input int wa, input int wd, input bit wrel, input string tag);
    bit relEff;
    relEff  = wrel & RelEn;
    rd_req  = rd;
    rd_addr = ADDR_W'(ra);
    pc_curr = PC_W'(pc);
    wr_en   = we;
    wr_addr = ADDR_W'(wa);
    wr_data = PC_W'(wd);
`ifdef PCT_REL_EN
    wr_rel  = wrel;
`endif
    mVld = 1'b0;
    if (mReady) begin
      if (rd) begin
        if (we && wa == ra) begin
          mTarget = resolve(wd, relEff, pc);
          mHit    = 1'b1;
        end else begin
          mTarget = resolve(mData[ra], mRel[ra], pc);
          mHit    = mValid[ra];
        end
        mVld = 1'b1;
      end
      if (we) begin
        mData[wa]  = wd;
        mValid[wa] = 1'b1;
        mRel[wa]   = relEff;
      end
    end else begin
      mInitLeft--;
      if (mInitLeft == 0) mReady = 1'b1;
    end
    @(posedge clk);
    #1;
    checkAll(tag);
  endtask

  task automatic idleCycle(input string tag);
    applyStimulus(1'b0, 0, 0, 1'b0, 0, 0, 1'b0, tag);
  endtask

  task automatic randomCycle(input string tag);
    applyStimulus(bit'($urandom_range(0, 1)), int'($urandom_range(0, DEPTH - 1)),
                  int'($urandom_range(0, 1023)), bit'($urandom_range(0, 2) == 0),
                  int'($urandom_range(0, DEPTH - 1)), int'($urandom_range(0, 1023)),
                  bit'($urandom_range(0, 1)), tag);
  endtask

  task automatic doReset(input int lowCycles);
    reset_n = 1'b0;
    rd_req  = 1'b0;
    wr_en   = 1'b0;
    #1;
    modelReset();
    checkAll("reset");
    repeat (lowCycles) begin
      @(posedge clk);
      #1;
      checkAll("resetHold");
    end
    reset_n = 1'b1;
  endtask

  initial begin
    reset_n = 1'b0;
    rd_req  = 1'b0;
    rd_addr = '0;
    pc_curr = '0;
    wr_en   = 1'b0;
    wr_addr = '0;
    wr_data = '0;
`ifdef PCT_REL_EN
    wr_rel  = 1'b0;
`endif
    @(posedge clk);
    #1;
    doReset(3);

    // Init period with random requests that must all be ignored
    repeat (DEPTH) randomCycle("init");
    idleCycle("postInit");

    // Unprogrammed lookup
    applyStimulus(1'b1, 5, 0, 1'b0, 0, 0, 1'b0, "rd5");
    idleCycle("rd5Hold");

    // Write, read, rewrite, read
    applyStimulus(1'b0, 0, 0, 1'b1, 2, 231, 1'b0, "wr2");
    applyStimulus(1'b1, 2, 0, 1'b0, 0, 0, 1'b0, "rd2");
    applyStimulus(1'b0, 0, 0, 1'b1, 2, 19, 1'b0, "rewr2");
    applyStimulus(1'b1, 2, 0, 1'b0, 0, 0, 1'b0, "rd2b");

    // Same-cycle bypass, then back-to-back reads
    applyStimulus(1'b1, 4, 0, 1'b1, 4, 335, 1'b0, "bypass4");
    applyStimulus(1'b1, 0, 0, 1'b0, 0, 0, 1'b0, "b2b0");
    applyStimulus(1'b1, 1, 0, 1'b0, 0, 0, 1'b0, "b2b1");
    applyStimulus(1'b1, 2, 0, 1'b0, 0, 0, 1'b0, "b2b2");
    idleCycle("b2bEnd");

`ifdef PCT_REL_EN
    // Relative entries with wrap-around
    applyStimulus(1'b0, 0, 0, 1'b1, 3, 10'h3FC, 1'b1, "wrRel3");
    applyStimulus(1'b1, 3, 20, 1'b0, 0, 0, 1'b0, "rel3pc20");
    checkOutput("rel3pc20.literal", int'(target), 16);
    applyStimulus(1'b1, 3, 0, 1'b0, 0, 0, 1'b0, "rel3pc0");
    checkOutput("rel3pc0.literal", int'(target), 1020);
    applyStimulus(1'b0, 0, 0, 1'b1, 5, 5, 1'b1, "wrRel5");
    applyStimulus(1'b1, 5, 1022, 1'b0, 0, 0, 1'b0, "rel5pc1022");
    checkOutput("rel5pc1022.literal", int'(target), 3);
`endif

    // Random traffic against the model
    repeat (400) randomCycle("rand");

    // Reset in the middle of init, then again after programming
    doReset(2);
    repeat (7) randomCycle("init7");
    doReset(3);
    repeat (DEPTH) randomCycle("reinit");
    repeat (40) randomCycle("prog");
    doReset(1);
    repeat (DEPTH) randomCycle("reinit2");
    for (int i = 0; i < DEPTH; i++) begin
      applyStimulus(1'b1, i, 0, 1'b0, 0, 0, 1'b0, "clearRd");
      checkOutput("clearRd.literalTarget", int'(target), i);
      checkOutput("clearRd.literalHit", int'(hit), 0);
    end
    idleCycle("end");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
